// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// operand forward-select codes and the EX/MEM scoreboard entry.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] write_reg;
    logic       wrenable;
    logic       mem_to_reg;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one scoreboard entry's destination against the decode-stage
// source registers; r0 never matches because it is hard-wired to zero.
module hazard_match
  import pipeline_ctrl_pkg::*;
(
  input  sb_entry_t  entry,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       match_rs1,
  output logic       match_rs2,
  output logic       match_any
);

  logic live;

  assign live      = id_valid && entry.valid && entry.wrenable && (entry.write_reg != 5'd0);
  assign match_rs1 = live && id_uses_rs1 && (entry.write_reg == id_rs1);
  assign match_rs2 = live && id_uses_rs2 && (entry.write_reg == id_rs2);
  assign match_any = match_rs1 || match_rs2;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble/flush sequencer for the 5-stage pipeline with a two-entry
// EX/MEM scoreboard. Define HAZARD_FWD_EN to build operand forwarding.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_write_reg,
  input  logic             id_reg_wrenable,
  input  logic             id_mem_to_reg,
  input  logic             should_jump,
  output logic             fd_stall,
  output logic             ex_bubble,
  output logic             mem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  ctrl_state_e state, state_next;
  logic [1:0]  flush_cnt, flush_cnt_next;
  sb_entry_t   exe_q, mme_q, exe_d;
  logic        exe_rs1, exe_rs2, exe_any;
  logic        mme_rs1, mme_rs2, mme_any;
  logic        hazard;

  assign exe_d      = '{valid: id_valid, write_reg: id_write_reg,
                        wrenable: id_reg_wrenable, mem_to_reg: id_mem_to_reg};
  assign ctrl_state = state;

  hazard_match u_match_exe (
    .entry(exe_q), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .match_rs1(exe_rs1), .match_rs2(exe_rs2), .match_any(exe_any)
  );

  hazard_match u_match_mme (
    .entry(mme_q), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .match_rs1(mme_rs1), .match_rs2(mme_rs2), .match_any(mme_any)
  );

`ifdef HAZARD_FWD_EN
  logic       unused_fwd;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  assign hazard     = exe_any && exe_q.mem_to_reg;
  assign unused_fwd = mme_any;
  assign fwd_a_sel  = (exe_rs1 && !exe_q.mem_to_reg) ? FWD_MEM : (mme_rs1 ? FWD_WB : FWD_RF);
  assign fwd_b_sel  = (exe_rs2 && !exe_q.mem_to_reg) ? FWD_MEM : (mme_rs2 ? FWD_WB : FWD_RF);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else if (ex_bubble) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else begin
      fwd_a <= fwd_a_sel;
      fwd_b <= fwd_b_sel;
    end
  end
`else
  logic unused_nofwd;

  // Without bypassing, any in-flight producer must reach the register file first.
  assign hazard       = exe_any || mme_any;
  assign unused_nofwd = ^{exe_rs1, exe_rs2, mme_rs1, mme_rs2};
  assign fwd_a        = FWD_RF;
  assign fwd_b        = FWD_RF;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      flush_cnt <= 2'd0;
      exe_q     <= '0;
      mme_q     <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      exe_q     <= ex_bubble ? '0 : exe_d;
      mme_q     <= mem_flush ? '0 : exe_q;
    end
  end

  // RUN and STALL share one rule set; STALL only records that a stall occurred.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    fd_stall       = 1'b0;
    ex_bubble      = 1'b0;
    mem_flush      = 1'b0;
    case (state)
      INIT: begin
        fd_stall   = 1'b1;
        ex_bubble  = 1'b1;
        state_next = RUN;
      end
      RUN, STALL: begin
        if (should_jump) begin
          mem_flush      = 1'b1;
          ex_bubble      = 1'b1;
          flush_cnt_next = FLUSH_LOAD;
          state_next     = FLUSH;
        end else if (hazard) begin
          fd_stall   = 1'b1;
          ex_bubble  = 1'b1;
          state_next = STALL;
        end else begin
          state_next = RUN;
        end
      end
      FLUSH: begin
        ex_bubble = 1'b1;
        if (flush_cnt == 2'd0) state_next = RUN;
        else flush_cnt_next = flush_cnt - 2'd1;
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (fd_stall && (state != INIT) && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
